pushbutton_debouncer: RTL and testbench

- Synchronizes and debounces one raw, asynchronous push-button input.
- Produces a clean level `PB_state`, plus one-cycle `PB_down` (press) and `PB_up` (release) pulses.
- Exposes the internal stability counter as `PB_cnt`.
- Sits between a board button pin and user logic, e.g. a digit-select counter clocked by `PB_state`.

---
 rtl/pushbutton_debouncer.sv | 81 ++++++++
 tb/tb_pushbutton_debouncer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pushbutton_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : pushbutton_debouncer
//  Description : Two-flop synchronizer plus saturating-free stability counter
//                that turns a bouncing push-button pin into a clean level and
//                one-cycle press/release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_debouncer #(
  parameter int CNT_WIDTH  = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PB,
  output logic                 PB_state,
  output logic                 PB_down,
  output logic                 PB_up,
  output logic [CNT_WIDTH-1:0] PB_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 w_pb_n;
  logic                 r_sync0;
  logic                 r_sync1;
  logic                 r_state;
  logic                 r_down;
  logic                 r_up;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_idle;
  logic                 w_cnt_max;

  // Normalize so that 1 always means "pressed" downstream
  assign w_pb_n    = ACTIVE_LOW ? ~PB : PB;
  assign w_idle    = (r_sync1 == r_state);
  assign w_cnt_max = &r_cnt;

  // Two-flop synchronizer; resets to the released level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= w_pb_n;
      r_sync1 <= r_sync0;
    end
  end

  // Stability counter, accepted level and registered edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_down  <= 1'b0;
      r_up    <= 1'b0;
    end else begin
      r_down <= 1'b0;
      r_up   <= 1'b0;
      if (w_idle) begin
        // Any return to the accepted level restarts the full count
        r_cnt <= '0;
      end else begin
        // All-ones rolls over to zero on the same edge that accepts
        r_cnt <= r_cnt + c_CNT_ONE;
        if (w_cnt_max) begin
          r_state <= ~r_state;
          r_down  <= ~r_state;
          r_up    <= r_state;
        end
      end
    end
  end

  assign PB_state = r_state;
  assign PB_down  = r_down;
  assign PB_up    = r_up;
  assign PB_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pushbutton_debouncer
//  Description : Directed, table-driven bench for pushbutton_debouncer with
//                CNT_WIDTH=4 (18-edge acceptance), both polarities.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pushbutton_debouncer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pb_a = 1'b1;
  logic          pb_b = 1'b0;
  logic          st_a, dn_a, up_a, st_b, dn_b, up_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;
  logic cur_state [2];

  // kind 0: counter must stay <= maxc every edge
  // kind 1: clean change from a settled level, counter follows n-2
  typedef struct {
    logic pb;
    int   hold;
    int   acc;
    logic fin;
    int   kind;
    int   maxc;
  } phase_t;

  phase_t tbl [19];

  pushbutton_debouncer #(.CNT_WIDTH(CW), .ACTIVE_LOW(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .PB(pb_a),
    .PB_state(st_a), .PB_down(dn_a), .PB_up(up_a), .PB_cnt(cnt_a)
  );

  pushbutton_debouncer #(.CNT_WIDTH(CW), .ACTIVE_LOW(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .PB(pb_b),
    .PB_state(st_b), .PB_down(dn_b), .PB_up(up_b), .PB_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic run_phase(input int sel, input phase_t p, input int idx);
    logic es, ed, eu;
    int   ec;
    logic s, d, u;
    int   c;
    if (sel == 0) pb_a = p.pb; else pb_b = p.pb;
    for (int n = 1; n <= p.hold; n++) begin
      @(posedge clk); #1;
      s = (sel == 0) ? st_a : st_b;
      d = (sel == 0) ? dn_a : dn_b;
      u = (sel == 0) ? up_a : up_b;
      c = (sel == 0) ? int'(cnt_a) : int'(cnt_b);
      es = (p.acc != 0 && n >= p.acc) ? p.fin : cur_state[sel];
      ed = (p.acc != 0 && n == p.acc && p.fin == 1'b1);
      eu = (p.acc != 0 && n == p.acc && p.fin == 1'b0);
      check($sformatf("phase%0d_dut%0d_state_e%0d", idx, sel, n), int'(s), int'(es));
      check($sformatf("phase%0d_dut%0d_down_e%0d", idx, sel, n), int'(d), int'(ed));
      check($sformatf("phase%0d_dut%0d_up_e%0d", idx, sel, n), int'(u), int'(eu));
      if (p.kind == 1) begin
        if (n <= 2 || (p.acc != 0 && n >= p.acc)) ec = 0;
        else ec = n - 2;
        check($sformatf("phase%0d_dut%0d_cnt_e%0d", idx, sel, n), c, ec);
      end else begin
        check($sformatf("phase%0d_dut%0d_cnt_bound_e%0d", idx, sel, n),
              int'(c <= p.maxc), 1);
      end
    end
    cur_state[sel] = p.fin;
  endtask

  initial begin
    phase_t p;
    bit     seen;

    // Hold released, accept press, accept release
    tbl[0] = '{pb:1'b1, hold:100, acc:0,  fin:1'b0, kind:0, maxc:0};
    tbl[1] = '{pb:1'b0, hold:40,  acc:18, fin:1'b1, kind:1, maxc:0};
    tbl[2] = '{pb:1'b1, hold:40,  acc:18, fin:1'b0, kind:1, maxc:0};
    // Bounce every 5 cycles for 60 cycles
    for (int i = 0; i < 12; i++)
      tbl[3+i] = '{pb:((i % 2) == 1), hold:5, acc:0, fin:1'b0, kind:0, maxc:5};
    // Settle pressed, then released
    tbl[15] = '{pb:1'b0, hold:30, acc:18, fin:1'b1, kind:1, maxc:0};
    tbl[16] = '{pb:1'b1, hold:30, acc:18, fin:1'b0, kind:1, maxc:0};
    // 15-cycle press is too short to be accepted
    tbl[17] = '{pb:1'b0, hold:15, acc:0,  fin:1'b0, kind:1, maxc:0};
    tbl[18] = '{pb:1'b1, hold:20, acc:0,  fin:1'b0, kind:0, maxc:15};

    cur_state[0] = 1'b0;
    cur_state[1] = 1'b0;

    // Reset for 3 cycles with both pins at their released level
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_state_a", int'(st_a), 0);
      check("reset_pulses_a", int'(dn_a | up_a), 0);
      check("reset_cnt_a", int'(cnt_a), 0);
      check("reset_state_b", int'(st_b), 0);
      check("reset_cnt_b", int'(cnt_b), 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 19; i++) run_phase(0, tbl[i], i);

    // Reset mid-count while pressed
    pb_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (cnt_a == 4'd10) seen = 1'b1;
    end
    check("midreset_cnt_reached_10", int'(seen), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_cnt", int'(cnt_a), 0);
    check("midreset_state", int'(st_a), 0);
    reset = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      check($sformatf("postreset_state_e%0d", n), int'(st_a), (n >= 18) ? 1 : 0);
      check($sformatf("postreset_down_e%0d", n), int'(dn_a), (n == 18) ? 1 : 0);
      check($sformatf("postreset_up_e%0d", n), int'(up_a), 0);
    end
    pb_a = 1'b1;
    cur_state[0] = 1'b1;

    // Active-high variant, starting settled released after the reset above
    repeat (5) @(posedge clk);
    #1;
    p = '{pb:1'b1, hold:30, acc:18, fin:1'b1, kind:1, maxc:0};
    run_phase(1, p, 100);
    p = '{pb:1'b0, hold:30, acc:18, fin:1'b0, kind:1, maxc:0};
    run_phase(1, p, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
